// File: rtl/sd_data_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_data_fifo_if
// Purpose  : Bundle of the block-data FIFO handshake and data signals shared
//            between the host register/DMA side, the SD data phy and the
//            FIFO itself.
// Ports    : master modport - drives direction, flush, host and phy strobes
//                             and write data; observes read data and status.
//            slave modport  - the FIFO view (inverse of master).
// Revision : 1.0  initial release
// ============================================================================
interface sd_data_fifo_if #(
    parameter int FIFO_data_size = 32,
    parameter int FIFO_depth     = 16,
    parameter int ADDR_W         = 4
);
    logic                      iWriteRead;
    logic                      iFlush;
    logic                      iHost_push;
    logic [FIFO_data_size-1:0] iHost_data;
    logic                      iHost_pop;
    logic [FIFO_data_size-1:0] oHost_data;
    logic                      iRead_enable;
    logic [FIFO_data_size-1:0] oData_from_FIFO;
    logic                      iWrite_enable;
    logic [FIFO_data_size-1:0] iData_to_FIFO;
    logic                      oFIFO_ok;
    logic                      oFull;
    logic                      oEmpty;
    logic [ADDR_W:0]           oCount;
    logic                      oOverflow;
    logic                      oUnderflow;

    modport master (
        output iWriteRead, iFlush, iHost_push, iHost_data, iHost_pop,
               iRead_enable, iWrite_enable, iData_to_FIFO,
        input  oHost_data, oData_from_FIFO, oFIFO_ok, oFull, oEmpty,
               oCount, oOverflow, oUnderflow
    );

    modport slave (
        input  iWriteRead, iFlush, iHost_push, iHost_data, iHost_pop,
               iRead_enable, iWrite_enable, iData_to_FIFO,
        output oHost_data, oData_from_FIFO, oFIFO_ok, oFull, oEmpty,
               oCount, oOverflow, oUnderflow
    );
endinterface
`default_nettype wire

// File: rtl/sd_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sd_data_fifo
// Purpose  : Bidirectional block data buffer between host and SD data phy.
//            iWriteRead=1: host pushes, phy pops (write to card).
//            iWriteRead=0: phy pushes, host pops (read from card).
// Ports    : iClock  - system clock, rising edge
//            iReset  - synchronous active-low reset
//            bus     - sd_data_fifo_if.slave: direction, flush, host/phy
//                      strobes and data, registered read data, occupancy
//                      flags/count, sticky overflow/underflow, oFIFO_ok
// Revision : 1.0  initial release
// ============================================================================
module sd_data_fifo #(
    parameter int FIFO_data_size = 32,
    parameter int FIFO_depth     = 16,
    parameter int ADDR_W         = 4
) (
    input  wire logic         iClock,
    input  wire logic         iReset,
    sd_data_fifo_if.slave     bus
);

    localparam logic [ADDR_W:0] c_depth = FIFO_depth[ADDR_W:0];

    logic [FIFO_data_size-1:0] r_mem [FIFO_depth];
    logic [ADDR_W-1:0]         r_wp;
    logic [ADDR_W-1:0]         r_rp;
    logic [ADDR_W:0]           r_count;
    logic                      r_full;
    logic                      r_empty;
    logic                      r_ovf;
    logic                      r_unf;
    logic [FIFO_data_size-1:0] r_host_data;
    logic [FIFO_data_size-1:0] r_phy_data;
    logic                      r_dir_q;

    logic                      w_clear;
    logic                      w_push_req;
    logic                      w_pop_req;
    logic [FIFO_data_size-1:0] w_push_data;
    logic                      w_push_ok;
    logic                      w_pop_ok;
    logic [ADDR_W:0]           w_count_nxt;

    // A direction change behaves like a flush on the first cycle the new
    // direction is seen, so stale data never crosses into the other mode.
    assign w_clear     = bus.iFlush | (bus.iWriteRead != r_dir_q);

    assign w_push_req  = bus.iWriteRead ? bus.iHost_push   : bus.iWrite_enable;
    assign w_pop_req   = bus.iWriteRead ? bus.iRead_enable : bus.iHost_pop;
    assign w_push_data = bus.iWriteRead ? bus.iHost_data   : bus.iData_to_FIFO;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_pop_ok    = w_pop_req & ~r_empty;
    assign w_push_ok   = w_push_req & (~r_full | w_pop_ok);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge iClock) begin
        r_dir_q <= bus.iWriteRead;
        if (!iReset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_host_data <= '0;
            r_phy_data  <= '0;
        end else if (w_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop_ok) begin
                r_rp <= r_rp + 1'b1;
                if (bus.iWriteRead) begin
                    r_phy_data <= r_mem[r_rp];
                end else begin
                    r_host_data <= r_mem[r_rp];
                end
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
            if (w_push_req && r_full && !w_pop_req) begin
                r_ovf <= 1'b1;
            end
            // A pop on empty paired with a push is simply dropped.
            if (w_pop_req && r_empty && !w_push_req) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Storage is never cleared; pointers alone define valid contents.
    always_ff @(posedge iClock) begin
        if (iReset && !w_clear && w_push_ok) begin
            r_mem[r_wp] <= w_push_data;
        end
    end

    assign bus.oHost_data      = r_host_data;
    assign bus.oData_from_FIFO = r_phy_data;
    assign bus.oCount          = r_count;
    assign bus.oFull           = r_full;
    assign bus.oEmpty          = r_empty;
    assign bus.oOverflow       = r_ovf;
    assign bus.oUnderflow      = r_unf;
    assign bus.oFIFO_ok        = bus.iWriteRead ? ~r_empty : ~r_full;

endmodule
`default_nettype wire

// File: tb/tb_sd_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_data_fifo
// Purpose  : Self-checking bench for sd_data_fifo. A queue-based reference
//            model tracks contents, output registers and sticky flags; every
//            clock the DUT outputs are compared against it. Directed scenarios
//            are followed by randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_data_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sd_data_fifo_if #(.FIFO_data_size(DW), .FIFO_depth(DEPTH), .ADDR_W(AW)) bus ();

    sd_data_fifo #(.FIFO_data_size(DW), .FIFO_depth(DEPTH), .ADDR_W(AW)) dut (
        .iClock (clk),
        .iReset (rst_n),
        .bus    (bus.slave)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_host;
    logic [DW-1:0] m_phy;
    logic          m_ovf;
    logic          m_unf;
    logic          m_prev_dir;

    int n_total = 0;
    int n_pass  = 0;

    task automatic model_edge();
        logic          push;
        logic          pop;
        logic [DW-1:0] d;
        push = bus.iWriteRead ? bus.iHost_push   : bus.iWrite_enable;
        pop  = bus.iWriteRead ? bus.iRead_enable : bus.iHost_pop;
        d    = bus.iWriteRead ? bus.iHost_data   : bus.iData_to_FIFO;
        if (!rst_n) begin
            q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_host = '0;
            m_phy  = '0;
        end else if (bus.iFlush || (bus.iWriteRead != m_prev_dir)) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pop) begin
                if (q.size() > 0) begin
                    if (bus.iWriteRead) m_phy  = q.pop_front();
                    else                m_host = q.pop_front();
                end else if (!push) begin
                    m_unf = 1'b1;
                end
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(d);
                else                  m_ovf = 1'b1;
            end
        end
        m_prev_dir = bus.iWriteRead;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // One clock: model follows the edge, then all outputs are compared.
    task automatic step();
        logic [DW-1:0] exp_cnt;
        @(posedge clk);
        model_edge();
        #1;
        exp_cnt = DW'(q.size());
        chk("count",     DW'(bus.oCount),     exp_cnt);
        chk("full",      DW'(bus.oFull),      DW'(q.size() == DEPTH));
        chk("empty",     DW'(bus.oEmpty),     DW'(q.size() == 0));
        chk("overflow",  DW'(bus.oOverflow),  DW'(m_ovf));
        chk("underflow", DW'(bus.oUnderflow), DW'(m_unf));
        chk("host_data", bus.oHost_data,      m_host);
        chk("phy_data",  bus.oData_from_FIFO, m_phy);
        chk("fifo_ok",   DW'(bus.oFIFO_ok),
            DW'(bus.iWriteRead ? (q.size() != 0) : (q.size() != DEPTH)));
    endtask

    task automatic idle();
        bus.iFlush        = 1'b0;
        bus.iHost_push    = 1'b0;
        bus.iHost_pop     = 1'b0;
        bus.iRead_enable  = 1'b0;
        bus.iWrite_enable = 1'b0;
    endtask

    task automatic fill_host(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.iHost_push = 1'b1;
            bus.iHost_data = base + DW'(i);
            step();
        end
        idle();
    endtask

    task automatic fill_phy(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.iWrite_enable = 1'b1;
            bus.iData_to_FIFO = base + DW'(i);
            step();
        end
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.iWriteRead    = 1'b1;
        bus.iHost_data    = '0;
        bus.iData_to_FIFO = '0;
        rst_n             = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state in write-to-card mode
        chk("pin_rst_empty",   DW'(bus.oEmpty),   DW'(1));
        chk("pin_rst_fifo_ok", DW'(bus.oFIFO_ok), DW'(0));
        chk("pin_rst_count",   DW'(bus.oCount),   DW'(0));

        bus.iHost_push = 1'b1;
        bus.iHost_data = 32'hA5A5_0001;
        step();
        idle();
        chk("pin_push_count",   DW'(bus.oCount),   DW'(1));
        chk("pin_push_fifo_ok", DW'(bus.oFIFO_ok), DW'(1));
        bus.iFlush = 1'b1;
        step();
        idle();

        // Fill to full, then overflow, then drain on the phy side
        fill_host(16, 32'h0);
        bus.iHost_push = 1'b1;
        bus.iHost_data = 32'hDEAD_BEEF;
        step();
        idle();
        chk("pin_full",      DW'(bus.oFull),     DW'(1));
        chk("pin_overflow",  DW'(bus.oOverflow), DW'(1));
        chk("pin_count16",   DW'(bus.oCount),    DW'(16));
        for (int i = 0; i < 16; i++) begin
            bus.iRead_enable = 1'b1;
            step();
            chk("pin_phy_order", bus.oData_from_FIFO, DW'(i));
        end
        idle();
        step();
        chk("pin_drained_empty", DW'(bus.oEmpty), DW'(1));
        chk("pin_model_empty",   DW'(q.size()),   DW'(0));

        // Read-from-card: phy streams 20 words, host drains from 2 cycles later
        bus.iWriteRead = 1'b0;
        step();
        for (int c = 0; c < 22; c++) begin
            bus.iWrite_enable = (c < 20);
            bus.iData_to_FIFO = 32'h100 + DW'(c);
            bus.iHost_pop     = (c >= 2);
            step();
            if (c >= 2) chk("pin_host_stream", bus.oHost_data, 32'h100 + DW'(c - 2));
        end
        idle();
        chk("pin_stream_no_ovf", DW'(bus.oOverflow), DW'(0));

        // Pop on empty, then push+pop on empty
        bus.iHost_pop = 1'b1;
        step();
        idle();
        chk("pin_underflow",      DW'(bus.oUnderflow), DW'(1));
        chk("pin_host_unchanged", bus.oHost_data,      32'h113);
        bus.iFlush = 1'b1;
        step();
        idle();
        bus.iHost_pop     = 1'b1;
        bus.iWrite_enable = 1'b1;
        bus.iData_to_FIFO = 32'h55;
        step();
        idle();
        chk("pin_pp_empty_count", DW'(bus.oCount),     DW'(1));
        chk("pin_pp_empty_unf",   DW'(bus.oUnderflow), DW'(0));

        // Full with simultaneous push and pop
        bus.iFlush = 1'b1;
        step();
        idle();
        fill_phy(16, 32'h200);
        bus.iHost_pop     = 1'b1;
        bus.iWrite_enable = 1'b1;
        bus.iData_to_FIFO = 32'h2FF;
        step();
        idle();
        chk("pin_full_pp_count", DW'(bus.oCount),    DW'(16));
        chk("pin_full_pp_ovf",   DW'(bus.oOverflow), DW'(0));
        chk("pin_full_pp_data",  bus.oHost_data,     32'h200);
        for (int i = 0; i < 16; i++) begin
            bus.iHost_pop = 1'b1;
            step();
        end
        idle();
        chk("pin_new_word_last", bus.oHost_data, 32'h2FF);

        // Clear by direction toggle, flush and reset with 5 words stored
        fill_phy(5, 32'h300);
        bus.iWriteRead = 1'b1;
        bus.iHost_push = 1'b1;
        step();
        idle();
        chk("pin_toggle_count", DW'(bus.oCount), DW'(0));
        chk("pin_toggle_empty", DW'(bus.oEmpty), DW'(1));
        fill_host(5, 32'h400);
        bus.iFlush     = 1'b1;
        bus.iHost_push = 1'b1;
        step();
        idle();
        chk("pin_flush_count", DW'(bus.oCount), DW'(0));
        fill_host(5, 32'h500);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("pin_reset_count", DW'(bus.oCount),          DW'(0));
        chk("pin_reset_phy",   bus.oData_from_FIFO,      DW'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.iFlush        = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0) bus.iWriteRead = ~bus.iWriteRead;
            rst_n             = ($urandom_range(0, 399) != 0);
            bus.iHost_push    = ($urandom_range(0, 99) < 55);
            bus.iHost_pop     = ($urandom_range(0, 99) < 45);
            bus.iRead_enable  = ($urandom_range(0, 99) < 45);
            bus.iWrite_enable = ($urandom_range(0, 99) < 55);
            bus.iHost_data    = $urandom;
            bus.iData_to_FIFO = $urandom;
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_data_fifo.md
# sd_data_fifo

Block data buffer between the host register/DMA side and the SD data physical layer. Holds 32-bit words: on writes to the card the host fills it and the physical layer drains it; on reads from the card the physical layer fills it and the host drains it. Direction follows the transfer direction issued by the data control block. Reports readiness to the control block through `oFIFO_ok`.

## Interface
- `FIFO_data_size`, 32: word width in bits.
- `FIFO_depth`, 16: number of words, power of two ≥ 2.
- `ADDR_W`, 4: log2(`FIFO_depth`).

Ports:
- `iClock`  in  1: single system clock; all state updates on its rising edge.
- `iReset`  in  1: synchronous, active-low reset, sampled on `iClock` rising edge.
- `iWriteRead`  in  1: transfer direction. 1 = host→card (host pushes, phy pops); 0 = card→host (phy pushes, host pops).
- `iFlush`  in  1: synchronous clear of pointers, count and error flags.
- `iHost_push`  in  1: host write strobe; honoured only when `iWriteRead`=1.
- `iHost_data`  in  `FIFO_data_size`: host write data.
- `iHost_pop`  in  1: host read strobe; honoured only when `iWriteRead`=0.
- `oHost_data`  out  `FIFO_data_size`: registered host read data.
- `iRead_enable`  in  1: phy pop strobe; honoured only when `iWriteRead`=1.
- `oData_from_FIFO`  out  `FIFO_data_size`: registered phy read data.
- `iWrite_enable`  in  1: phy push strobe; honoured only when `iWriteRead`=0.
- `iData_to_FIFO`  in  `FIFO_data_size`: phy write data.
- `oFIFO_ok`  out  1: phy side may proceed.
- `oFull`, `oEmpty`  out  1: occupancy flags.
- `oCount`  out  `ADDR_W+1`: occupancy, 0..`FIFO_depth`.
- `oOverflow`, `oUnderflow`  out  1: sticky error flags.

## Operation
- Storage: `FIFO_depth` × `FIFO_data_size` register array; write pointer `wp`, read pointer `rp`, each `ADDR_W` bits, wrapping from `FIFO_depth-1` to 0. Count is tracked in a separate `ADDR_W+1`-bit counter.
- Push source is selected by `iWriteRead`: host (`iHost_push`/`iHost_data`) when 1, phy (`iWrite_enable`/`iData_to_FIFO`) when 0. Pop source is the opposite side. Strobes from the inactive side are ignored and raise no error.
- Push: when not full, or full with a simultaneous pop, write the data at `wp` and increment `wp`. Push while full without a pop drops the data and sets `oOverflow`.
- Pop: when not empty, load the word at `rp` into the active output register (`oData_from_FIFO` if `iWriteRead`=1, else `oHost_data`) and increment `rp`. Pop while empty leaves the output register unchanged and sets `oUnderflow`.
- Simultaneous push and pop:
  - Non-empty: both take effect; count is unchanged.
  - Empty: only the push takes effect; no underflow is flagged; the pop is dropped.
- `oFIFO_ok` is `!oEmpty` when `iWriteRead`=1 (data available to serialize). It is `!oFull` when `iWriteRead`=0 (space to receive).
- A change of `iWriteRead` between consecutive cycles acts as an implicit flush on the cycle the new value is first sampled. That cycle's strobes are ignored.
- `iFlush` has priority over push and pop. `iReset` low has priority over everything.
- Error flags clear only on reset or flush.

## Timing
- Reset (`iReset`=0 at an edge): `wp`=`rp`=0, `oCount`=0, `oEmpty`=1, `oFull`=0, `oOverflow`=`oUnderflow`=0, `oHost_data`=0, `oData_from_FIFO`=0. `oFIFO_ok` is then 1 if `iWriteRead`=0, else 0. The storage array is not cleared.
- Pop latency: the data appears on the output register the edge after the sampled strobe, and holds until the next successful pop.
- Push→pop: a word pushed at edge N is poppable at edge N+1 (`oEmpty` falls after edge N).
- `oCount`, `oFull`, `oEmpty` and the error flags are registered and update on the same edge as the pointers. `oFIFO_ok` is combinational from `oFull`/`oEmpty`/`iWriteRead`.
- Reset or flush in mid-transfer discards contents at that edge; strobes in that cycle have no effect.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, `iWriteRead`=1 → all outputs at reset values, `oEmpty`=1, `oFIFO_ok`=0. Then push 0xA5A5_0001 → next cycle `oCount`=1, `oFIFO_ok`=1.
- Host pushes 16 words 0x0..0xF, then one more push → `oFull`=1, `oOverflow`=1, `oCount`=16. `iRead_enable` 16 cycles → `oData_from_FIFO` = 0x0..0xF in order, one cycle after each strobe; `oEmpty`=1.
- `iWriteRead`=0: phy pushes 20 words with the host draining 1 per cycle starting 2 cycles later → no overflow, data order preserved across pointer wrap, `oFIFO_ok` stays 1.
- Pop on empty (`iHost_pop`, `iWriteRead`=0) → `oUnderflow`=1, `oHost_data` unchanged. Simultaneous push+pop on empty → `oCount`=1, no underflow.
- Full FIFO with simultaneous push and pop → `oCount` stays 16, no overflow, new word lands last.
- With 5 words stored, toggle `iWriteRead` (or pulse `iFlush`, or pulse `iReset` low) → next cycle `oCount`=0, `oEmpty`=1, error flags cleared.
